// File: rtl/ram_io_responder.sv
// ram_io_responder
//
// Responder end of the CPU's byte-wide memory bus. Addresses with
// mem_a[17:16] != 2'b11 go to a byte RAM; mem_a[17:16] == 2'b11 selects the
// I/O region (UART TX FIFO, optional UART RX FIFO, halt register). Reads
// return on mem_din exactly one cycle after the address is presented.
//
// Build option: define IO_RX_EN to include the RX FIFO. Without it,
// rx_data/rx_valid are ignored, RX reads return 0, RX pops are ignored and
// the rx_empty status bit reads 1.
//
// Ports:
//   clk_in, rst_in   clock, asynchronous active-high reset
//   mem_a            byte address (bits 17:0 decoded)
//   mem_wr           1 = write, 0 = read
//   mem_dout         write data from the CPU
//   mem_din          registered read data to the CPU
//   io_buffer_full   registered TX near-full indication to the CPU
//   tx_data/valid    FWFT head of the TX FIFO towards the UART transmitter
//   tx_ready         UART transmitter accepts the head byte
//   rx_data/valid    bytes from the UART receiver
//   sim_done         sticky, set by a write to 0x30004
//   tx_overflow      sticky, set when a TX push was dropped
module ram_io_responder #(
    parameter int ADDR_WIDTH   = 17,
    parameter int TX_DEPTH_LOG = 3,
    parameter int RX_DEPTH_LOG = 3,
    parameter int FULL_MARGIN  = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] mem_a,
    input  logic        mem_wr,
    input  logic [7:0]  mem_dout,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        sim_done,
    output logic        tx_overflow
);

    localparam int TX_DEPTH = 1 << TX_DEPTH_LOG;
    localparam logic [TX_DEPTH_LOG:0]   TX_FULL_CNT = (TX_DEPTH_LOG + 1)'(TX_DEPTH);
    localparam logic [TX_DEPTH_LOG:0]   TX_NEAR_CNT = (TX_DEPTH_LOG + 1)'(TX_DEPTH - FULL_MARGIN);
    localparam logic [TX_DEPTH_LOG:0]   TX_CNT_ONE  = (TX_DEPTH_LOG + 1)'(1);
    localparam logic [TX_DEPTH_LOG-1:0] TX_PTR_ONE  = (TX_DEPTH_LOG)'(1);

    localparam logic [3:0] OFF_DATA   = 4'h0;
    localparam logic [3:0] OFF_STATUS = 4'h4;
    localparam logic [3:0] OFF_RXPOP  = 4'h8;

    // Address decode
    logic                  io_sel;
    logic [3:0]            io_off;
    logic [ADDR_WIDTH-1:0] ram_idx;
    logic                  unused_addr;

    assign io_sel      = (mem_a[17:16] == 2'b11);
    assign io_off      = mem_a[3:0];
    assign ram_idx     = mem_a[ADDR_WIDTH-1:0];
    assign unused_addr = ^mem_a[31:18];

    // Byte RAM (contents survive reset)
    logic [7:0] ram [1 << ADDR_WIDTH];

    always_ff @(posedge clk_in) begin
        if (mem_wr && !io_sel) begin
            ram[ram_idx] <= mem_dout;
        end
    end

    // TX FIFO
    logic [7:0]              tx_mem [TX_DEPTH];
    logic [TX_DEPTH_LOG-1:0] tx_wr_ptr_q, tx_rd_ptr_q;
    logic [TX_DEPTH_LOG:0]   tx_cnt_q, tx_cnt_d;
    logic                    tx_valid_q, io_full_q, tx_ovf_q;
    logic                    tx_full, tx_push_req, tx_push, tx_pop;

    assign tx_full     = (tx_cnt_q == TX_FULL_CNT);
    assign tx_push_req = mem_wr && io_sel && (io_off == OFF_DATA);
    assign tx_pop      = tx_valid_q && tx_ready;
    // A push into a full FIFO still lands when the head leaves in the same cycle.
    assign tx_push     = tx_push_req && (!tx_full || tx_pop);

    always_comb begin
        tx_cnt_d = tx_cnt_q;
        case ({tx_push, tx_pop})
            2'b10:   tx_cnt_d = tx_cnt_q + TX_CNT_ONE;
            2'b01:   tx_cnt_d = tx_cnt_q - TX_CNT_ONE;
            default: tx_cnt_d = tx_cnt_q;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (tx_push) begin
            tx_mem[tx_wr_ptr_q] <= mem_dout;
        end
    end

    // Valid and near-full are registered from the next count so both line
    // up with the stored data; near-full leaves room for the CPU's reaction delay.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            tx_wr_ptr_q <= '0;
            tx_rd_ptr_q <= '0;
            tx_cnt_q    <= '0;
            tx_valid_q  <= 1'b0;
            io_full_q   <= 1'b0;
            tx_ovf_q    <= 1'b0;
        end else begin
            if (tx_push) begin
                tx_wr_ptr_q <= tx_wr_ptr_q + TX_PTR_ONE;
            end
            if (tx_pop) begin
                tx_rd_ptr_q <= tx_rd_ptr_q + TX_PTR_ONE;
            end
            tx_cnt_q   <= tx_cnt_d;
            tx_valid_q <= (tx_cnt_d != '0);
            io_full_q  <= (tx_cnt_d >= TX_NEAR_CNT);
            if (tx_push_req && !tx_push) begin
                tx_ovf_q <= 1'b1;
            end
        end
    end

    // Gating keeps stale storage off tx_data while empty or just after reset.
    assign tx_data        = tx_valid_q ? tx_mem[tx_rd_ptr_q] : 8'h00;
    assign tx_valid       = tx_valid_q;
    assign io_buffer_full = io_full_q;
    assign tx_overflow    = tx_ovf_q;

    // RX FIFO (optional)
    logic       rx_empty;
    logic [7:0] rx_head;

`ifdef IO_RX_EN
    localparam int RX_DEPTH = 1 << RX_DEPTH_LOG;
    localparam logic [RX_DEPTH_LOG:0]   RX_FULL_CNT = (RX_DEPTH_LOG + 1)'(RX_DEPTH);
    localparam logic [RX_DEPTH_LOG:0]   RX_CNT_ONE  = (RX_DEPTH_LOG + 1)'(1);
    localparam logic [RX_DEPTH_LOG-1:0] RX_PTR_ONE  = (RX_DEPTH_LOG)'(1);

    logic [7:0]              rx_mem [RX_DEPTH];
    logic [RX_DEPTH_LOG-1:0] rx_wr_ptr_q, rx_rd_ptr_q;
    logic [RX_DEPTH_LOG:0]   rx_cnt_q, rx_cnt_d;
    logic                    rx_push, rx_pop;

    assign rx_empty = (rx_cnt_q == '0);
    assign rx_push  = rx_valid && (rx_cnt_q != RX_FULL_CNT);
    assign rx_pop   = mem_wr && io_sel && (io_off == OFF_RXPOP) && !rx_empty;
    assign rx_head  = rx_empty ? 8'h00 : rx_mem[rx_rd_ptr_q];

    always_comb begin
        rx_cnt_d = rx_cnt_q;
        case ({rx_push, rx_pop})
            2'b10:   rx_cnt_d = rx_cnt_q + RX_CNT_ONE;
            2'b01:   rx_cnt_d = rx_cnt_q - RX_CNT_ONE;
            default: rx_cnt_d = rx_cnt_q;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rx_push) begin
            rx_mem[rx_wr_ptr_q] <= rx_data;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rx_wr_ptr_q <= '0;
            rx_rd_ptr_q <= '0;
            rx_cnt_q    <= '0;
        end else begin
            if (rx_push) begin
                rx_wr_ptr_q <= rx_wr_ptr_q + RX_PTR_ONE;
            end
            if (rx_pop) begin
                rx_rd_ptr_q <= rx_rd_ptr_q + RX_PTR_ONE;
            end
            rx_cnt_q <= rx_cnt_d;
        end
    end
`else
    logic unused_rx;

    assign rx_empty  = 1'b1;
    assign rx_head   = 8'h00;
    assign unused_rx = ^{rx_data, rx_valid};
`endif

    // Read data: writes return 0, RAM and I/O reads use pre-edge state.
    logic [7:0] mem_din_d, mem_din_q;
    logic       sim_done_q;

    always_comb begin
        mem_din_d = 8'h00;
        if (!mem_wr) begin
            if (!io_sel) begin
                mem_din_d = ram[ram_idx];
            end else begin
                case (io_off)
                    OFF_DATA:   mem_din_d = rx_head;
                    OFF_STATUS: mem_din_d = {6'b000000, rx_empty, tx_full};
                    default:    mem_din_d = 8'h00;
                endcase
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            mem_din_q  <= 8'h00;
            sim_done_q <= 1'b0;
        end else begin
            mem_din_q <= mem_din_d;
            if (mem_wr && io_sel && (io_off == OFF_STATUS)) begin
                sim_done_q <= 1'b1;
            end
        end
    end

    assign mem_din  = mem_din_q;
    assign sim_done = sim_done_q;

endmodule

// File: tb/tb_ram_io_responder.sv
// tb_ram_io_responder
//
// Self-checking bench for ram_io_responder. A queue/associative-array model
// of the RAM, TX FIFO and RX FIFO predicts every output; each scenario task
// drives its own stimulus and compares inline.
module tb_ram_io_responder;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        sim_done;
    logic        tx_overflow;

    int checks = 0;
    int passes = 0;

    ram_io_responder dut (
        .clk_in(clk_in), .rst_in(rst_in), .mem_a(mem_a), .mem_wr(mem_wr),
        .mem_dout(mem_dout), .mem_din(mem_din), .io_buffer_full(io_buffer_full),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .sim_done(sim_done),
        .tx_overflow(tx_overflow)
    );

    always #5 clk_in = ~clk_in;

    // Reference model state
    logic [7:0] ram_m [int];
    logic [7:0] txq[$];
    logic [7:0] rxq[$];
    logic       m_ovf;
    logic       m_done;
    logic [7:0] m_din;
    logic       m_chk;

    function automatic logic m_rx_empty();
`ifdef IO_RX_EN
        return rxq.size() == 0;
`else
        return 1'b1;
`endif
    endfunction

    // Advance the model by one clock using the inputs currently driven,
    // then let the DUT take the same edge and settle.
    task automatic step();
        logic       io;
        logic [3:0] off;
        logic       rx_was_full;
        io  = (mem_a[17:16] == 2'b11);
        off = mem_a[3:0];
        m_chk = 1'b1;
        if (mem_wr) m_din = 8'h00;
        else if (!io) begin
            if (ram_m.exists(int'(mem_a[16:0]))) m_din = ram_m[int'(mem_a[16:0])];
            else begin m_din = 8'h00; m_chk = 1'b0; end
        end
        else if (off == 4'h0) m_din = (!m_rx_empty()) ? rxq[0] : 8'h00;
        else if (off == 4'h4) m_din = {6'b0, m_rx_empty(), txq.size() == 8};
        else m_din = 8'h00;

        if (txq.size() != 0 && tx_ready) void'(txq.pop_front());
        if (mem_wr && io && off == 4'h0) begin
            if (txq.size() < 8) txq.push_back(mem_dout);
            else m_ovf = 1'b1;
        end
        if (mem_wr && io && off == 4'h4) m_done = 1'b1;
        if (mem_wr && !io) ram_m[int'(mem_a[16:0])] = mem_dout;
`ifdef IO_RX_EN
        rx_was_full = (rxq.size() == 8);
        if (mem_wr && io && off == 4'h8 && rxq.size() != 0) void'(rxq.pop_front());
        if (rx_valid && !rx_was_full) rxq.push_back(rx_data);
`else
        rx_was_full = 1'b0;
`endif
        @(posedge clk_in);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [7:0] d);
        mem_a = a; mem_wr = 1'b1; mem_dout = d;
        step();
        mem_wr = 1'b0; mem_a = 32'h0;
    endtask

    task automatic bus_read(input logic [31:0] a);
        mem_a = a; mem_wr = 1'b0;
        step();
        mem_a = 32'h0;
    endtask

    task automatic do_reset();
        rst_in = 1'b1; mem_wr = 1'b0; mem_a = 32'h0; mem_dout = 8'h00;
        tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        txq.delete(); rxq.delete();
        m_ovf = 1'b0; m_done = 1'b0; m_din = 8'h00;
        @(posedge clk_in); #3;
        rst_in = 1'b0;
        @(posedge clk_in); #1;
    endtask

    function automatic logic [31:0] ram_addr(input logic [16:0] low);
        logic [31:0] a;
        a = $urandom;
        a[16:0] = low;
        a[17] = low[16] ? 1'b0 : 1'($urandom_range(0, 1));
        return a;
    endfunction

    task automatic test_reset();
        rst_in = 1'b1; mem_wr = 1'b0; mem_a = 32'h0; mem_dout = 8'h00;
        tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        #12;
        checks++; if (mem_din !== 8'h00) $display("[TB] FAIL reset_mem_din got %h want 00", mem_din); else passes++;
        checks++; if (tx_valid !== 1'b0) $display("[TB] FAIL reset_tx_valid got %b want 0", tx_valid); else passes++;
        checks++; if (tx_data !== 8'h00) $display("[TB] FAIL reset_tx_data got %h want 00", tx_data); else passes++;
        checks++; if (io_buffer_full !== 1'b0) $display("[TB] FAIL reset_full got %b want 0", io_buffer_full); else passes++;
        checks++; if (sim_done !== 1'b0) $display("[TB] FAIL reset_sim_done got %b want 0", sim_done); else passes++;
        checks++; if (tx_overflow !== 1'b0) $display("[TB] FAIL reset_ovf got %b want 0", tx_overflow); else passes++;
        do_reset();
    endtask

    task automatic test_ram_basic();
        bus_write(32'h0000_0010, 8'hA5);
        bus_read(32'h0000_0010);
        checks++; if (mem_din !== 8'hA5) $display("[TB] FAIL ram_read_a5 got %h want a5", mem_din); else passes++;
        bus_write(32'h0000_0011, 8'h3C);
        checks++; if (mem_din !== 8'h00) $display("[TB] FAIL write_cycle_din got %h want 00", mem_din); else passes++;
    endtask

    task automatic test_ram_random();
        logic [16:0] pool [16];
        int idx;
        for (int i = 0; i < 16; i++) pool[i] = 17'($urandom);
        for (int i = 0; i < 80; i++) begin
            idx = $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 1 || !ram_m.exists(int'(pool[idx]))) begin
                bus_write(ram_addr(pool[idx]), 8'($urandom));
            end else begin
                bus_read(ram_addr(pool[idx]));
                checks++; if (mem_din !== m_din) $display("[TB] FAIL ram_rand_read addr %h got %h want %h", pool[idx], mem_din, m_din); else passes++;
            end
        end
    endtask

    task automatic test_tx_full();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            bus_write(32'h0003_0000, 8'(8'h41 + i));
            checks++; if (io_buffer_full !== (txq.size() >= 6)) $display("[TB] FAIL full_push%0d got %b want %b", i, io_buffer_full, txq.size() >= 6); else passes++;
        end
        checks++; if (io_buffer_full !== 1'b1) $display("[TB] FAIL full_after6 got %b want 1", io_buffer_full); else passes++;
        checks++; if (tx_valid !== 1'b1) $display("[TB] FAIL full_tx_valid got %b want 1", tx_valid); else passes++;
        checks++; if (tx_data !== 8'h41) $display("[TB] FAIL full_tx_head got %h want 41", tx_data); else passes++;
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 9; i++) begin
            bus_write(32'h0003_0000, 8'($urandom));
            checks++; if (tx_overflow !== m_ovf) $display("[TB] FAIL ovf_push%0d got %b want %b", i, tx_overflow, m_ovf); else passes++;
        end
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++; if (tx_valid !== 1'b1 || tx_data !== txq[0]) $display("[TB] FAIL ovf_drain%0d got %b/%h want 1/%h", i, tx_valid, tx_data, txq[0]); else passes++;
            step();
        end
        checks++; if (tx_valid !== 1'b0) $display("[TB] FAIL ovf_drained_valid got %b want 0", tx_valid); else passes++;
        tx_ready = 1'b0;
    endtask

    task automatic test_push_pop_full();
        do_reset();
        for (int i = 0; i < 8; i++) bus_write(32'h0003_0000, 8'(8'h10 + i));
        tx_ready = 1'b1;
        bus_write(32'h0003_0000, 8'h99);
        tx_ready = 1'b0;
        checks++; if (tx_overflow !== 1'b0) $display("[TB] FAIL ppf_ovf got %b want 0", tx_overflow); else passes++;
        bus_read(32'h0003_0004);
        checks++; if (mem_din !== 8'h03) $display("[TB] FAIL ppf_status got %h want 03", mem_din); else passes++;
        checks++; if (tx_data !== 8'h11) $display("[TB] FAIL ppf_head got %h want 11", tx_data); else passes++;
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++; if (tx_data !== txq[0]) $display("[TB] FAIL ppf_drain%0d got %h want %h", i, tx_data, txq[0]); else passes++;
            if (i == 7) begin
                checks++; if (tx_data !== 8'h99) $display("[TB] FAIL ppf_last got %h want 99", tx_data); else passes++;
            end
            step();
        end
        tx_ready = 1'b0;
    endtask

    task automatic test_rx();
        do_reset();
        rx_data = 8'h5A; rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus_read(32'h0003_0000);
            checks++; if (mem_din !== m_din) $display("[TB] FAIL rx_head%0d got %h want %h", i, mem_din, m_din); else passes++;
        end
        bus_write(32'h0003_0008, 8'h00);
        bus_read(32'h0003_0004);
        checks++; if (mem_din !== 8'h02) $display("[TB] FAIL rx_status got %h want 02", mem_din); else passes++;
        for (int i = 0; i < 120; i++) begin
            rx_valid = 1'($urandom_range(0, 2) == 0);
            rx_data = 8'($urandom);
            case ($urandom_range(0, 2))
                0: begin mem_a = 32'h0003_0000; mem_wr = 1'b0; end
                1: begin mem_a = 32'h0003_0004; mem_wr = 1'b0; end
                default: begin mem_a = 32'h0003_0008; mem_wr = 1'b1; end
            endcase
            step();
            if (!mem_wr) begin
                checks++; if (mem_din !== m_din) $display("[TB] FAIL rx_rand%0d got %h want %h", i, mem_din, m_din); else passes++;
            end
        end
        rx_valid = 1'b0; mem_wr = 1'b0; mem_a = 32'h0;
    endtask

    task automatic test_random_io();
        logic [31:0] a;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            tx_ready = 1'($urandom_range(0, 2) == 0);
            mem_dout = 8'($urandom);
            case ($urandom_range(0, 5))
                0, 1: begin mem_a = 32'h0003_0000 | ($urandom & 32'hFFFC_FFF0); mem_a[17:16] = 2'b11; mem_wr = 1'b1; end
                2:    begin mem_a = 32'h0003_0004; mem_wr = 1'b0; end
                3:    begin mem_a = 32'h0003_000C; mem_wr = 1'($urandom_range(0, 1)); end
                4:    begin a = ram_addr(17'h100 + 17'($urandom_range(0, 15))); mem_a = a; mem_wr = 1'b1; end
                default: begin a = ram_addr(17'h100 + 17'($urandom_range(0, 15))); mem_a = a; mem_wr = 1'b0; end
            endcase
            step();
            checks++; if (tx_valid !== (txq.size() != 0)) $display("[TB] FAIL rnd_valid%0d got %b want %b", i, tx_valid, txq.size() != 0); else passes++;
            checks++; if (tx_data !== ((txq.size() != 0) ? txq[0] : 8'h00)) $display("[TB] FAIL rnd_data%0d got %h", i, tx_data); else passes++;
            checks++; if (io_buffer_full !== (txq.size() >= 6)) $display("[TB] FAIL rnd_full%0d got %b want %b", i, io_buffer_full, txq.size() >= 6); else passes++;
            checks++; if (tx_overflow !== m_ovf) $display("[TB] FAIL rnd_ovf%0d got %b want %b", i, tx_overflow, m_ovf); else passes++;
            if (m_chk) begin
                checks++; if (mem_din !== m_din) $display("[TB] FAIL rnd_din%0d got %h want %h", i, mem_din, m_din); else passes++;
            end
        end
        mem_wr = 1'b0; mem_a = 32'h0; tx_ready = 1'b0;
    endtask

    task automatic test_sim_done_reset();
        do_reset();
        for (int i = 0; i < 3; i++) bus_write(32'h0003_0000, 8'(8'hC0 + i));
        bus_write(32'h0003_0004, 8'h00);
        checks++; if (sim_done !== m_done) $display("[TB] FAIL done_set got %b want %b", sim_done, m_done); else passes++;
        checks++; if (tx_valid !== 1'b1) $display("[TB] FAIL done_tx_busy got %b want 1", tx_valid); else passes++;
        bus_write(32'h0003_0000, 8'hC3);
        checks++; if (sim_done !== 1'b1) $display("[TB] FAIL done_sticky got %b want 1", sim_done); else passes++;
        #2;
        rst_in = 1'b1;
        #1;
        checks++; if (sim_done !== 1'b0) $display("[TB] FAIL async_done got %b want 0", sim_done); else passes++;
        checks++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) $display("[TB] FAIL async_tx got %b/%h want 0/00", tx_valid, tx_data); else passes++;
        checks++; if (io_buffer_full !== 1'b0 || mem_din !== 8'h00) $display("[TB] FAIL async_misc got %b/%h want 0/00", io_buffer_full, mem_din); else passes++;
        do_reset();
        checks++; if (tx_valid !== 1'b0) $display("[TB] FAIL post_reset_valid got %b want 0", tx_valid); else passes++;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_ram_basic();
        test_ram_random();
        test_tx_full();
        test_overflow();
        test_push_pop_full();
        test_rx();
        test_random_io();
        test_sim_done_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
